// File: rtl/seq_input_conditioner.sv
// seq_input_conditioner
//   Turns two raw, bouncy board buttons into clean clk-synchronous inputs for
//   the T-trigger sequential circuit. Each button is synchronised (2 flops),
//   debounced by its own four-state channel FSM, and then edge-detected. The
//   outputs are a one-cycle step pulse, an x level (button level or
//   per-press toggle), a pulse on every x change, and a wrapping press count.
//
//   Optional feature macro: AUTO_PATTERN_EN
//     When defined, the auto_en input, the PAT_LEN/PATTERN parameters and a
//     pattern index are added. With auto_en=1 every step press loads
//     x from PATTERN (bit 0 first) and btn_x/x_mode are ignored.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_t      in   raw step button (asynchronous)
//   btn_x      in   raw x button (asynchronous)
//   x_mode     in   0: x follows button level, 1: x toggles per press
//   auto_en    in   (AUTO_PATTERN_EN only) drive x from PATTERN
//   t          out  one-cycle pulse per accepted btn_t press
//   x          out  registered x level
//   x_changed  out  one-cycle pulse, aligned with each new x value
//   press_cnt  out  number of t pulses issued, wraps at 256
module seq_input_conditioner #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 5
`ifdef AUTO_PATTERN_EN
  ,
  parameter int unsigned          PAT_LEN = 8,
  parameter logic [PAT_LEN-1:0]   PATTERN = 8'b1011_0010
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_t,
  input  logic       btn_x,
  input  logic       x_mode,
`ifdef AUTO_PATTERN_EN
  input  logic       auto_en,
`endif
  output logic       t,
  output logic       x,
  output logic       x_changed,
  output logic [7:0] press_cnt
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    PRESSED,
    RELEASING
  } ch_state_t;

  // Channel index: bit 0 = step button, bit 1 = x button.
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] stable;
  logic [1:0] stable_d;
  logic [1:0] rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_x, btn_t};
      sync2 <= sync1;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    ch_state_t        st_q;
    ch_state_t        st_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             s;

    assign s = sync2[ch];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    // The counter only runs in the two transitional states; any sample
    // matching the current stable level drops back and clears it.
    always_comb begin
      st_d  = st_q;
      cnt_d = '0;
      case (st_q)
        IDLE, ARMING: begin
          if (s) begin
            if (cnt_q == DEB_LAST) begin
              st_d = PRESSED;
            end else begin
              st_d  = ARMING;
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            st_d = IDLE;
          end
        end
        PRESSED, RELEASING: begin
          if (!s) begin
            if (cnt_q == DEB_LAST) begin
              st_d = IDLE;
            end else begin
              st_d  = RELEASING;
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            st_d = PRESSED;
          end
        end
        default: st_d = IDLE;
      endcase
    end

    assign stable[ch] = (st_q == PRESSED) || (st_q == RELEASING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  assign rise = stable & ~stable_d;

  logic x_next;

`ifdef AUTO_PATTERN_EN
  localparam int unsigned      IDX_W    = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_LEN - 1);

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;

  always_comb begin
    x_next   = x;
    idx_next = idx;
    if (auto_en) begin
      if (rise[0]) begin
        x_next   = PATTERN[idx];
        idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end else if (x_mode) begin
      x_next = x ^ rise[1];
    end else begin
      x_next = stable[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else begin
      idx <= idx_next;
    end
  end
`else
  always_comb begin
    x_next = x;
    if (x_mode) begin
      x_next = x ^ rise[1];
    end else begin
      x_next = stable[1];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t         <= 1'b0;
      x         <= 1'b0;
      x_changed <= 1'b0;
      press_cnt <= '0;
    end else begin
      t         <= rise[0];
      x         <= x_next;
      x_changed <= x_next ^ x;
      press_cnt <= press_cnt + {7'd0, rise[0]};
    end
  end

endmodule

// File: tb/tb_seq_input_conditioner.sv
module tb_seq_input_conditioner;

  localparam int unsigned DEB = 4;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       btn_t  = 1'b0;
  logic       btn_x  = 1'b0;
  logic       x_mode = 1'b0;
  logic       auto_en_v = 1'b0;
  logic       t;
  logic       x;
  logic       x_changed;
  logic [7:0] press_cnt;

  logic [7:0] pat_v = 8'b1011_0010;

  int checks = 0;
  int errors = 0;

  seq_input_conditioner #(
    .DEB_CYCLES(DEB),
    .CNT_W(5)
`ifdef AUTO_PATTERN_EN
    ,
    .PAT_LEN(8),
    .PATTERN(8'b1011_0010)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_t(btn_t),
    .btn_x(btn_x),
    .x_mode(x_mode),
`ifdef AUTO_PATTERN_EN
    .auto_en(auto_en_v),
`endif
    .t(t),
    .x(x),
    .x_changed(x_changed),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a button level is accepted once the last DEB
  // synchronised samples all show the opposite level.
  bit       m_s1   [2];
  bit       m_s2   [2];
  bit       m_stab [2];
  bit       m_rise [2];
  bit       m_hist [2][DEB];
  bit       m_t;
  bit       m_x;
  bit       m_xc;
  bit [7:0] m_cnt;
  int       m_idx;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_stab[c] = 0; m_rise[c] = 0;
      for (int i = 0; i < int'(DEB); i++) m_hist[c][i] = 0;
    end
    m_t = 0; m_x = 0; m_xc = 0; m_cnt = 0; m_idx = 0;
  endtask

  task automatic model_step();
    bit raw [2];
    bit old_x;
    bit all_opp;
    raw[0] = btn_t;
    raw[1] = btn_x;
    old_x  = m_x;
    m_t    = m_rise[0];
    if (m_rise[0]) m_cnt = m_cnt + 8'd1;
`ifdef AUTO_PATTERN_EN
    if (auto_en_v) begin
      if (m_rise[0]) begin
        m_x   = pat_v[m_idx];
        m_idx = (m_idx + 1) % 8;
      end
    end else
`endif
    if (x_mode) m_x = m_x ^ m_rise[1];
    else        m_x = m_stab[1];
    m_xc = (m_x != old_x);
    for (int c = 0; c < 2; c++) begin
      for (int i = int'(DEB) - 1; i > 0; i--) m_hist[c][i] = m_hist[c][i-1];
      m_hist[c][0] = m_s2[c];
      all_opp = 1;
      for (int i = 0; i < int'(DEB); i++)
        if (m_hist[c][i] == m_stab[c]) all_opp = 0;
      m_rise[c] = all_opp && !m_stab[c];
      if (all_opp) m_stab[c] = !m_stab[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("t", t, m_t);
      chk("x", x, m_x);
      chk("x_changed", x_changed, m_xc);
      chk("press_cnt", press_cnt, m_cnt);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_t(input int hold, input int total,
                       output int first, output int pulses, output logic x_at_t);
    first = 0; pulses = 0; x_at_t = 0;
    btn_t = 1'b1;
    for (int i = 1; i <= total; i++) begin
      @(posedge clk); #1;
      if (t) begin
        pulses++;
        if (first == 0) begin first = i; x_at_t = x; end
      end
      @(negedge clk);
      if (i == hold) btn_t = 1'b0;
    end
  endtask

  task automatic run_x(input int hold, input int total,
                       output int xc_cnt, output logic x_after);
    xc_cnt = 0; x_after = 0;
    btn_x = 1'b1;
    for (int i = 1; i <= total; i++) begin
      @(posedge clk); #1;
      if (x_changed) xc_cnt++;
      if (i == hold) x_after = x;
      @(negedge clk);
      if (i == hold) btn_x = 1'b0;
    end
  endtask

  int   first;
  int   pulses;
  int   acc;
  int   xc_tot;
  int   xc;
  logic xv;
  logic [2:0] exp_x;
  logic [8:0] exp_seq;

  initial begin
    // Reset and idle.
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (t || x || x_changed || press_cnt != 0) acc++;
      @(negedge clk);
    end
    chk("idle_nonzero_cycles", acc, 0);

    // Clean press held 10 cycles.
    run_t(10, 30, first, pulses, xv);
    chk("clean_latency", first, 7);
    chk("clean_pulses", pulses, 1);
    chk("clean_press_cnt", press_cnt, 1);

    // Bounce 1,0,1,1,0 then steady 1.
    btn_t = 1'b1; cyc(1);
    btn_t = 1'b0; cyc(1);
    btn_t = 1'b1; cyc(2);
    btn_t = 1'b0; cyc(1);
    run_t(12, 30, first, pulses, xv);
    chk("bounce_latency", first, 7);
    chk("bounce_pulses", pulses, 1);
    chk("bounce_press_cnt", press_cnt, 2);

    // Toggle mode: three presses give x = 1,0,1.
    x_mode = 1'b1;
    cyc(1);
    xc_tot = 0;
    exp_x  = 3'b101;
    for (int k = 0; k < 3; k++) begin
      run_x(8, 16, xc, xv);
      xc_tot += xc;
      chk("toggle_x", xv, exp_x[k]);
    end
    chk("toggle_xc_pulses", xc_tot, 3);
    chk("toggle_x_before_level", x, 1);
    x_mode = 1'b0;
    @(posedge clk); #1;
    chk("level_x", x, 0);
    chk("level_xc", x_changed, 1);
    @(negedge clk);

    // 256 presses wrap the counter.
    rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(1);
    acc = 0;
    for (int k = 1; k <= 256; k++) begin
      run_t(8, 16, first, pulses, xv);
      acc += pulses;
      if (k == 255) chk("cnt_255", press_cnt, 255);
    end
    chk("wrap_pulses", acc, 256);
    chk("wrap_cnt", press_cnt, 0);

    // Reset in the middle of press 257's debounce.
    btn_t = 1'b1;
    cyc(3);
    rst_n = 1'b0;
    #1;
    chk("rst_t", t, 0);
    chk("rst_x", x, 0);
    chk("rst_xc", x_changed, 0);
    chk("rst_cnt", press_cnt, 0);
    btn_t = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (t) acc++;
      @(negedge clk);
    end
    chk("post_rst_pulses", acc, 0);
    chk("post_rst_cnt", press_cnt, 0);

`ifdef AUTO_PATTERN_EN
    // Pattern playback: x arrives together with each t pulse.
    auto_en_v = 1'b1;
    btn_x     = 1'b1;
    exp_seq   = 9'b0_1011_0010;
    for (int k = 0; k < 9; k++) begin
      run_t(8, 16, first, pulses, xv);
      chk("auto_pulses", pulses, 1);
      chk("auto_x_at_t", xv, exp_seq[k]);
    end
    auto_en_v = 1'b0;
    btn_x     = 1'b0;
    cyc(10);
`endif

    // Randomised activity, checked cycle by cycle against the model.
    for (int k = 0; k < 250; k++) begin
      btn_t = 1'($urandom_range(0, 1));
      btn_x = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) x_mode = ~x_mode;
`ifdef AUTO_PATTERN_EN
      if ($urandom_range(0, 15) == 0) auto_en_v = ~auto_en_v;
`endif
      if ($urandom_range(0, 60) == 0) begin
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
      end
      cyc($urandom_range(1, 12));
    end

    btn_t = 1'b0;
    btn_x = 1'b0;
    cyc(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_input_conditioner.md
Name: seq_input_conditioner

Overview:
- Upstream input stage for the T-trigger synchronous sequential circuit.
- Takes two raw, bouncy board buttons and produces the clean, clk-synchronous `t` and `x` inputs that circuit consumes.
- Provides synchronisation, per-channel debounce, a one-cycle `t` step pulse, a level/toggle `x` source and a press counter for display.

Parameters:
- DEB_CYCLES, 16: consecutive stable synchronised samples required to accept a new button level (legal range 2..2^CNT_W-1).
- CNT_W, 5: width of each debounce counter.
- PAT_LEN, 8: pattern length, used only with AUTO_PATTERN_EN.
- PATTERN, 8'b1011_0010: x pattern, bit 0 first, used only with AUTO_PATTERN_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_t  in  1  raw step button, asynchronous to clk.
- btn_x  in  1  raw x button, asynchronous to clk.
- x_mode  in  1  0 = x follows button level, 1 = x toggles per press.
- t  out  1  one-cycle step pulse per accepted btn_t press.
- x  out  1  registered x level to downstream.
- x_changed  out  1  one-cycle pulse whenever x changes value.
- press_cnt  out  8  count of t pulses issued.

Behaviour:
- Reset is asynchronous and active-low on rst_n. While rst_n=0, every flop clears: synchronisers, debounce counters, stable levels, t=0, x=0, x_changed=0, press_cnt=0.
- Deassertion of rst_n is sampled on the next clk edge.
- Reset asserted mid-debounce discards the partial count. No pulse is emitted.
- Synchroniser: 2-flop chain per button gives sync_t and sync_x.
- Debounce (per channel, independent):
  - if sync == stable, the counter clears to 0;
  - else the counter increments;
  - when the counter == DEB_CYCLES-1 and sync still differs, stable <= sync and the counter clears.
  - Any bounce back to the stable value before acceptance restarts counting from 0.
- Channel state machine (per channel):
  - IDLE (stable=0) -> ARMING on sync=1.
  - ARMING -> PRESSED after DEB_CYCLES consecutive 1s; back to IDLE on any 0.
  - PRESSED -> RELEASING on sync=0.
  - RELEASING -> IDLE after DEB_CYCLES consecutive 0s; back to PRESSED on any 1.
- Rising edge of stable (IDLE/ARMING -> PRESSED) = rise event.
- Latency: raw edge to rise event = 2 + DEB_CYCLES cycles. Outputs are registered one further cycle.
- t: asserted for exactly one cycle, the cycle after the btn_t rise event. Release produces nothing. Holding the button produces only one pulse.
- x, level mode (x_mode=0): x <= stable_x every cycle.
- x, toggle mode (x_mode=1): x <= x ^ rise_x.
- x_mode is sampled every cycle:
  - switching 0->1 holds the current x;
  - switching 1->0 makes x track stable_x from the next cycle.
- x_changed: 1 for one cycle whenever the registered x differs from its previous value. It is aligned with the new x value.
- press_cnt: increments by 1 in the same edge that sets t=1. Wraps 255 -> 0 with no flag.
- Simultaneous rise events on both channels are handled in the same cycle: t pulse and x update coincide. The downstream block sees t and the new x together.
- All outputs are glitch-free registers; there are no combinational paths from the btn_* inputs.

Optional Feature:
- Macro: AUTO_PATTERN_EN.
- Defined:
  - adds input port auto_en (1 bit);
  - adds a pattern index register idx of clog2(PAT_LEN) bits, reset to 0.
- With auto_en=1:
  - btn_x and x_mode are ignored;
  - on each btn_t rise event, the block sets t=1, x <= PATTERN[idx], and idx <= (idx==PAT_LEN-1) ? 0 : idx+1, all in the same edge;
  - x_changed still pulses if x changes.
- With auto_en=0: behaviour is identical to the undefined build; idx holds its value.
- Not defined: no auto_en port, no idx, no pattern logic.

Test Plan:
- DEB_CYCLES=4, rst_n low then high, no buttons -> t=0, x=0, x_changed=0, press_cnt=0 for 20 cycles.
- Clean btn_t press held 10 cycles -> t high exactly once, at cycle 7 after the raw edge; press_cnt=1; release gives no pulse.
- btn_t bounce 1,0,1,1,0 then steady 1 -> only one t pulse, 2+4+1 cycles after the last raw 0->1 edge.
- x_mode=1, three clean btn_x presses -> x goes 1,0,1 with three x_changed pulses. Then x_mode=0 with button released -> x=0 next cycle and one x_changed pulse.
- 256 clean btn_t presses -> press_cnt wraps to 0 on the 256th pulse. Assert rst_n=0 mid-debounce of press 257 -> all outputs 0 and no pulse after release of reset.
- With AUTO_PATTERN_EN and auto_en=1: 9 btn_t presses -> x sequence 0,1,0,0,1,1,0,1,0 (idx wraps after 8), with each value present in the same cycle as its t pulse.
